// File: rtl/level_meter_display_pkg.sv
// ---------------------------------------------------------------------------
// level_meter_pkg
// Shared types and constants for the level meter display block.
//   peak_state_t : peak-hold FSM states (IDLE / HOLD / DECAY)
//   LEVEL_MAX    : highest legal level code; larger inputs are clamped to it
//   SEG_*        : active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
package level_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DECAY = 2'd2
  } peak_state_t;

  localparam logic [3:0] LEVEL_MAX = 4'd9;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Clamp a raw 4-bit level code into the 0..9 range.
  function automatic logic [3:0] clamp_level(input logic [3:0] raw);
    return (raw > LEVEL_MAX) ? LEVEL_MAX : raw;
  endfunction

endpackage

// File: rtl/level_meter_display_if.sv
// ---------------------------------------------------------------------------
// level_meter_display_if
// Level-update bus from the histogram stage into the meter display.
//   level_in    : level code, meaningful only while level_valid=1
//   level_valid : one-cycle strobe marking a new level
//   hold_en     : 1 = peak hold/decay active, 0 = peak follows the level
//   clear       : synchronous clear of the level/peak/hold state
// master drives the bus (histogram stage / testbench), slave receives it.
// ---------------------------------------------------------------------------
interface level_meter_display_if;

  logic [3:0] level_in;
  logic       level_valid;
  logic       hold_en;
  logic       clear;

  modport master (
    output level_in,
    output level_valid,
    output hold_en,
    output clear
  );

  modport slave (
    input level_in,
    input level_valid,
    input hold_en,
    input clear
  );

endinterface

// File: rtl/level_meter_display_seg7.sv
// ---------------------------------------------------------------------------
// seg7_decoder
// Combinational decimal digit to active-low 7-segment decoder.
//   digit : 4-bit value; 0..9 show the numeral, 10..15 show blank
//   seg   : active-low segments {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module seg7_decoder
  import level_meter_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/level_meter_display.sv
// ---------------------------------------------------------------------------
// level_meter_display
// Turns the histogram stage's winning level code into board outputs:
// a 10-LED thermometer bar with a peak dot, current/peak 7-segment digits
// and a blinking overload flag. Peak hold follows an IDLE/HOLD/DECAY FSM
// that advances only on level strobes.
// Ports:
//   clock    : system clock
//   resetn   : synchronous active-low reset
//   bus      : level update bus (level_in, level_valid, hold_en, clear)
//   ledr     : bar graph, bits [cur:0] lit plus bit [peak]
//   hex_cur  : active-low segments of the current level
//   hex_peak : active-low segments of the peak level
//   overload : blinks while the latched level is at/above OVERLOAD_LEVEL
// ---------------------------------------------------------------------------
module level_meter_display
  import level_meter_pkg::*;
#(
  parameter int HOLD_WINDOWS   = 4,
  parameter int BLINK_DIV      = 12500000,
  parameter int OVERLOAD_LEVEL = 9
) (
  input  logic                  clock,
  input  logic                  resetn,
  level_meter_display_if.slave  bus,
  output logic [9:0]            ledr,
  output logic [6:0]            hex_cur,
  output logic [6:0]            hex_peak,
  output logic                  overload
);

  localparam int         BLINK_W     = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [3:0] HOLD_RELOAD = 4'(HOLD_WINDOWS);
  localparam logic [3:0] OVL_LEVEL   = 4'(OVERLOAD_LEVEL);

  peak_state_t  state_q, state_d;
  logic [3:0]   cur_q, cur_d;
  logic [3:0]   peak_q, peak_d;
  logic [3:0]   hold_q, hold_d;
  logic [3:0]   level_clamped;

  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_ph;

  logic [9:0]   bar;
  logic [6:0]   seg_cur;
  logic [6:0]   seg_peak;

  assign level_clamped = clamp_level(bus.level_in);

  // Level/peak/hold state registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      cur_q   <= 4'd0;
      peak_q  <= 4'd0;
      hold_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      peak_q  <= peak_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic for the peak FSM; clear outranks a simultaneous strobe.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    peak_d  = peak_q;
    hold_d  = hold_q;
    if (bus.clear) begin
      state_d = IDLE;
      cur_d   = 4'd0;
      peak_d  = 4'd0;
      hold_d  = 4'd0;
    end else if (bus.level_valid) begin
      cur_d = level_clamped;
      if (!bus.hold_en) begin
        state_d = IDLE;
        peak_d  = level_clamped;
        hold_d  = 4'd0;
      end else begin
        case (state_q)
          IDLE: begin
            peak_d = level_clamped;
            if (level_clamped > peak_q) begin
              hold_d  = HOLD_RELOAD;
              state_d = HOLD;
            end
          end
          HOLD: begin
            // An equal level counts as fresh activity and re-arms the hold.
            if (level_clamped >= peak_q) begin
              peak_d = level_clamped;
              hold_d = HOLD_RELOAD;
            end else if (hold_q > 4'd1) begin
              hold_d = hold_q - 4'd1;
            end else begin
              hold_d  = 4'd0;
              state_d = DECAY;
            end
          end
          DECAY: begin
            // Here level < peak implies peak >= 1, so peak-1 cannot wrap.
            if (level_clamped >= peak_q) begin
              peak_d  = level_clamped;
              hold_d  = HOLD_RELOAD;
              state_d = HOLD;
            end else if ((peak_q - 4'd1) <= level_clamped) begin
              peak_d  = level_clamped;
              state_d = IDLE;
            end else begin
              peak_d = peak_q - 4'd1;
            end
          end
          default: begin
            state_d = IDLE;
            peak_d  = level_clamped;
            hold_d  = 4'd0;
          end
        endcase
      end
    end
  end

  // Free-running blink divider; clear deliberately leaves it alone.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blink_ph  <= ~blink_ph;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Thermometer bar with the peak dot OR-ed in.
  always_comb begin
    bar = '0;
    for (int i = 0; i < 10; i++) begin
      bar[i] = (4'(i) <= cur_q) || (4'(i) == peak_q);
    end
  end

  seg7_decoder u_seg_cur (
    .digit (cur_q),
    .seg   (seg_cur)
  );

  seg7_decoder u_seg_peak (
    .digit (peak_q),
    .seg   (seg_peak)
  );

  // Output registers: one cycle behind the level/peak registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ledr     <= 10'b0000000001;
      hex_cur  <= SEG_0;
      hex_peak <= SEG_0;
      overload <= 1'b0;
    end else begin
      ledr     <= bar;
      hex_cur  <= seg_cur;
      hex_peak <= seg_peak;
      overload <= blink_ph & (cur_q >= OVL_LEVEL);
    end
  end

endmodule

// File: tb/tb_level_meter_display.sv
// ---------------------------------------------------------------------------
// tb_level_meter_display
// Self-checking bench for level_meter_display with a behavioural model.
// ---------------------------------------------------------------------------
module tb_level_meter_display;

  localparam int HOLD_WINDOWS   = 4;
  localparam int BLINK_DIV      = 4;
  localparam int OVERLOAD_LEVEL = 9;

  logic       clock;
  logic       resetn;
  logic [9:0] ledr;
  logic [6:0] hex_cur;
  logic [6:0] hex_peak;
  logic       overload;

  int checks = 0;
  int errors = 0;

  level_meter_display_if bus_if ();

  level_meter_display #(
    .HOLD_WINDOWS   (HOLD_WINDOWS),
    .BLINK_DIV      (BLINK_DIV),
    .OVERLOAD_LEVEL (OVERLOAD_LEVEL)
  ) dut (
    .clock    (clock),
    .resetn   (resetn),
    .bus      (bus_if.slave),
    .ledr     (ledr),
    .hex_cur  (hex_cur),
    .hex_peak (hex_peak),
    .overload (overload)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Digit patterns written out from the segment drawing of each numeral.
  logic [6:0] digit_seg [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Behavioural model: mode 0 = tracking, 1 = holding, 2 = decaying.
  int         m_cur, m_peak, m_left, m_mode, m_ticks;
  bit         model_ok = 1'b0;
  logic [9:0] exp_ledr;
  logic [6:0] exp_hc, exp_hp;
  logic       exp_ovl;

  function automatic logic [9:0] bar_of(input int c, input int p);
    logic [9:0] b;
    b = '0;
    for (int i = 0; i < 10; i++) if (i <= c || i == p) b[i] = 1'b1;
    return b;
  endfunction

  always @(posedge clock) begin
    int lv;
    if (!resetn) begin
      m_cur = 0; m_peak = 0; m_left = 0; m_mode = 0; m_ticks = 0;
      exp_ledr = 10'h001; exp_hc = digit_seg[0]; exp_hp = digit_seg[0];
      exp_ovl = 1'b0;
      model_ok = 1'b1;
    end else begin
      exp_ledr = bar_of(m_cur, m_peak);
      exp_hc   = digit_seg[m_cur];
      exp_hp   = digit_seg[m_peak];
      exp_ovl  = (((m_ticks / BLINK_DIV) % 2) == 1) && (m_cur >= OVERLOAD_LEVEL);
      m_ticks++;
      if (bus_if.clear) begin
        m_cur = 0; m_peak = 0; m_left = 0; m_mode = 0;
      end else if (bus_if.level_valid) begin
        lv = (int'(bus_if.level_in) > 9) ? 9 : int'(bus_if.level_in);
        m_cur = lv;
        if (!bus_if.hold_en) begin
          m_peak = lv; m_left = 0; m_mode = 0;
        end else if (m_mode == 0) begin
          if (lv > m_peak) begin m_left = HOLD_WINDOWS; m_mode = 1; end
          m_peak = lv;
        end else if (m_mode == 1) begin
          if (lv >= m_peak) begin m_peak = lv; m_left = HOLD_WINDOWS; end
          else begin
            m_left = m_left - 1;
            if (m_left <= 0) begin m_left = 0; m_mode = 2; end
          end
        end else begin
          if (lv >= m_peak) begin m_peak = lv; m_left = HOLD_WINDOWS; m_mode = 1; end
          else if (lv + 1 >= m_peak) begin m_peak = lv; m_mode = 0; end
          else m_peak = m_peak - 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model on the falling edge.
  always @(negedge clock) begin
    if (model_ok) begin
      checks++;
      if (ledr !== exp_ledr || hex_cur !== exp_hc || hex_peak !== exp_hp ||
          overload !== exp_ovl) begin
        errors++;
        $display("[TB] FAIL model_cmp t=%0t got ledr=%h hc=%b hp=%b ovl=%b want ledr=%h hc=%b hp=%b ovl=%b",
                 $time, ledr, hex_cur, hex_peak, overload, exp_ledr, exp_hc, exp_hp, exp_ovl);
      end
    end
  end

  // Drive one cycle of inputs, then advance to just after the next edge.
  task automatic applyStimulus(input logic [3:0] lvl, input logic vld,
                               input logic hen, input logic clr, input logic rstn);
    bus_if.level_in    = lvl;
    bus_if.level_valid = vld;
    bus_if.hold_en     = hen;
    bus_if.clear       = clr;
    resetn             = rstn;
    @(posedge clock);
    #1;
  endtask

  // Strobe a level then idle one cycle so the outputs reflect it.
  task automatic pulse(input logic [3:0] lvl, input logic hen);
    applyStimulus(lvl, 1'b1, hen, 1'b0, 1'b1);
    applyStimulus(4'd0, 1'b0, hen, 1'b0, 1'b1);
  endtask

  task automatic checkOutput(input string name, input logic [9:0] e_ledr,
                             input logic [6:0] e_hc, input logic [6:0] e_hp);
    checks++;
    if (ledr !== e_ledr || hex_cur !== e_hc || hex_peak !== e_hp) begin
      errors++;
      $display("[TB] FAIL %s got ledr=%h hc=%b hp=%b want ledr=%h hc=%b hp=%b",
               name, ledr, hex_cur, hex_peak, e_ledr, e_hc, e_hp);
    end
  endtask

  task automatic checkBit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got %b want %b", name, got, want);
    end
  endtask

  initial begin
    int ones;
    logic hen;
    bus_if.level_in = 4'd0; bus_if.level_valid = 1'b0;
    bus_if.hold_en = 1'b1;  bus_if.clear = 1'b0;
    resetn = 1'b0;
    @(posedge clock); #1;

    // Reset held three cycles while a strobe is presented.
    repeat (3) applyStimulus(4'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("reset", 10'h001, 7'b1000000, 7'b1000000);
    checkBit("reset_ovl", overload, 1'b0);
    applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);

    // Rise, hold and decay.
    pulse(4'd3, 1'b1);
    pulse(4'd8, 1'b1);
    checkOutput("rise_8", 10'h1FF, 7'b0000000, 7'b0000000);
    repeat (3) pulse(4'd2, 1'b1);
    checkOutput("hold_8", 10'h107, 7'b0100100, 7'b0000000);
    pulse(4'd2, 1'b1);
    checkOutput("enter_decay", 10'h107, 7'b0100100, 7'b0000000);
    pulse(4'd2, 1'b1); checkOutput("decay_7", 10'h087, 7'b0100100, 7'b1111000);
    pulse(4'd2, 1'b1); checkOutput("decay_6", 10'h047, 7'b0100100, 7'b0000010);
    pulse(4'd2, 1'b1); checkOutput("decay_5", 10'h027, 7'b0100100, 7'b0010010);
    pulse(4'd2, 1'b1); checkOutput("decay_4", 10'h017, 7'b0100100, 7'b0011001);
    pulse(4'd2, 1'b1); checkOutput("decay_3", 10'h00F, 7'b0100100, 7'b0110000);
    pulse(4'd2, 1'b1); checkOutput("decay_2", 10'h007, 7'b0100100, 7'b0100100);
    pulse(4'd2, 1'b1); checkOutput("idle_2", 10'h007, 7'b0100100, 7'b0100100);

    // Clamp and overload blink.
    pulse(4'd13, 1'b1);
    checkOutput("clamp_13", 10'h3FF, 7'b0010000, 7'b0010000);
    ones = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      if (overload === 1'b1) ones++;
    end
    @(posedge clock); #1;
    checks++;
    if (ones != 8) begin
      errors++;
      $display("[TB] FAIL blink_duty got %0d high cycles want 8", ones);
    end
    pulse(4'd5, 1'b1);
    checkBit("ovl_drop", overload, 1'b0);
    checkOutput("after_drop", 10'h23F, 7'b0010010, 7'b0010000);

    // Clear beats a simultaneous strobe.
    applyStimulus(4'd6, 1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("clear_prio", 10'h001, 7'b1000000, 7'b1000000);
    pulse(4'd6, 1'b1);
    checkOutput("after_clear", 10'h07F, 7'b0000010, 7'b0000010);

    // Hold disabled: peak tracks immediately.
    pulse(4'd9, 1'b0);
    pulse(4'd1, 1'b0);
    checkOutput("no_hold", 10'h003, 7'b1111001, 7'b1111001);

    // Randomized traffic checked by the model.
    hen = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(99) < 5) hen = ~hen;
      applyStimulus(4'($urandom_range(15)), ($urandom_range(99) < 45), hen,
                    ($urandom_range(99) < 3), ($urandom_range(99) >= 2));
    end
    applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/level_meter_display.md
Name: level_meter_display

Overview:
- Downstream consumer of the decibel histogram stage. It takes the winning 0–9 level code and its one-cycle update strobe, and turns them into board-visible outputs.
- Current level and peak-hold are held in registers.
- Drives a 10-LED thermometer bar with a peak dot, two active-low 7-segment digits (current, peak) and a blinking overload flag.
- Sits between the histogram counter and the DE1-SoC LEDR/HEX pins.

Parameters:
- HOLD_WINDOWS, 4: number of update strobes the peak is held before decay starts (1..15).
- BLINK_DIV, 12500000: clock cycles per overload blink half-period (≥2).
- OVERLOAD_LEVEL, 9: level at or above which the overload flag is raised (0..9).

Ports:
- clock  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  synchronous, active-low reset.
- level_in  in  4  level code from the histogram stage; valid only when level_valid=1.
- level_valid  in  1  one-cycle strobe; new level available.
- hold_en  in  1  1 = peak-hold/decay active; 0 = peak tracks current level.
- clear  in  1  synchronous clear of level/peak/hold state (ignored during reset).
- ledr  out  10  bar graph: bits [cur:0] lit, plus bit [peak] lit.
- hex_cur  out  7  active-low segments {g,f,e,d,c,b,a} for the current level digit.
- hex_peak  out  7  active-low segments for the peak digit.
- overload  out  1  blinks at BLINK_DIV rate while the latched level ≥ OVERLOAD_LEVEL.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - cur=0, peak=0, hold_cnt=0, state=IDLE, blink_cnt=0, blink_ph=0.
  - Outputs one cycle later: ledr=10'b0000000001, hex_cur=hex_peak=7'b1000000 ("0"), overload=0.
  - Reset mid-operation aborts hold/decay immediately.
- Input clamp: level_in>9 is treated as 9. All internal level registers are 4 bits and never exceed 9.
- All outputs are registered. Latency is 1 cycle from the level_valid edge to the cur/peak update, and 1 further cycle to ledr/hex/overload.
- level_valid=0: cur, peak, hold_cnt and state are unchanged.
- clear=1: same effect as reset on cur/peak/hold/state. It takes priority over a simultaneous level_valid. The blink counter is unaffected.
- Peak FSM (evaluated on level_valid=1, using clamped L; cur<=L always):
  - hold_en=0: peak<=L, state<=IDLE, hold_cnt<=0.
  - IDLE:
    - If L>peak: peak<=L, hold_cnt<=HOLD_WINDOWS, go to HOLD.
    - Otherwise: peak<=L.
  - HOLD:
    - If L≥peak: peak<=L, hold_cnt<=HOLD_WINDOWS (retrigger; equal level also retriggers).
    - Else if hold_cnt>1: hold_cnt--.
    - Else: hold_cnt<=0, go to DECAY.
  - DECAY:
    - If L≥peak: peak<=L, hold_cnt<=HOLD_WINDOWS, go to HOLD.
    - Else if peak-1≤L: peak<=L, go to IDLE.
    - Else: peak<=peak-1 (one step per strobe).
- Invariant: peak≥cur at all times when hold_en=1. Transiently violated only by clear, which zeroes both.
- Bar: ledr[i]=1 for i≤cur, and ledr[peak]=1. When peak==cur the dot coincides with the bar.
- Overload:
  - blink_cnt counts 0..BLINK_DIV-1, wraps to 0 and toggles blink_ph on wrap. It runs continuously.
  - overload = blink_ph & (cur≥OVERLOAD_LEVEL).
  - If cur drops below the threshold, overload clears on the next cycle.
- Simultaneous events: resetn > clear > level_valid. hold_en changes take effect at the next strobe only.

Decomposition:
- Package level_meter_pkg holds:
  - state enum IDLE/HOLD/DECAY (2-bit);
  - LEVEL_MAX=4'd9;
  - SEG_* active-low constants for digits 0–9 and blank.
- Sub-module seg7_decoder: 4-bit in, 7-bit active-low out, combinational. Values 10–15 show blank (7'b1111111).
- Instantiated twice (cur, peak); its outputs are registered in the parent.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with level_valid=1, level_in=7 → ledr=10'h001, both hex=7'b1000000, overload=0.
- Rise and hold (hold_en=1, HOLD_WINDOWS=4):
  - Strobes 3,8 → after 8: ledr=10'h1FF, hex_peak="8" (7'b0000000).
  - Strobes 2,2,2 → peak stays 8, ledr=10'h107.
- Decay: continue strobes of 2 after hold expiry (4th low strobe enters DECAY) → peak steps 7,6,5,4,3, then 2 and IDLE. Further strobes of 2 keep ledr=10'h007.
- Clamp/overload: strobe level_in=4'd13 with BLINK_DIV=4 → cur=9, ledr=10'h3FF, overload toggles every 4 cycles. Then strobe 5 → overload=0 within 2 cycles.
- Priority: clear=1 and level_valid=1 (level 6) in the same cycle → cur=peak=0, state IDLE. Next strobe 6 → cur=peak=6.
- hold_en=0: strobes 9,1 → peak follows to 1 immediately, ledr=10'h003.
